roic_pixel_sequencer: RTL and testbench
=======================================

# roic_pixel_sequencer

Per-pixel analog phase sequencer for the 640x512 ROIC readout chain; sits directly downstream of the row/column traversal FSM. For each pixel address handed over by the traversal stage it drives the pixel reset, integrate and sample-and-hold phases, then handshakes one conversion with the column ADC. It presents the digitised sample, tagged with its row/column address, to the frame buffer via a valid/ready output.

## Interface
- `ROW_W`, 9: row address width (512 rows)
- `COL_W`, 10: column address width (640 columns)
- `DATA_W`, 14: ADC sample width
- `T_RST`, 4: pixel reset phase length, cycles (≥1)
- `T_INT`, 100: integration phase length, cycles (≥1)
- `T_SH`, 2: sample-and-hold phase length, cycles (≥1)
- `ADC_TIMEOUT`, 64: max CONVERT cycles awaiting `adc_done` (≥2)

- `clk` in 1: single system clock
- `rst` in 1: reset, asynchronous, active-low
- `addr_valid` in 1: traversal stage presents a pixel address
- `addr_ready` out 1: sequencer accepts an address (high only in IDLE)
- `row_addr` in ROW_W: pixel row
- `col_addr` in COL_W: pixel column
- `px_rst` out 1: pixel reset switch
- `px_int` out 1: integration enable
- `px_sh` out 1: sample-and-hold strobe
- `adc_start` out 1: one-cycle conversion request
- `adc_done` in 1: conversion complete, `adc_data` valid this cycle
- `adc_data` in DATA_W: conversion result
- `out_valid` out 1: output sample valid
- `out_ready` in 1: downstream accepts sample
- `out_row` out ROW_W, `out_col` out COL_W: address tag of the sample
- `out_data` out DATA_W: sample value
- `out_err` out 1: sample produced by ADC timeout
- `busy` out 1: state ≠ IDLE

## Operation
- States: IDLE → RESET → INTEGRATE → SAMPLE → CONVERT → OUTPUT → IDLE.
- IDLE: `addr_ready`=1; on `addr_valid & addr_ready`, latch `row_addr`/`col_addr`, load phase counter with T_RST, go RESET.
- RESET: `px_rst`=1 for exactly T_RST cycles, then INTEGRATE (counter T_INT), `px_int`=1 for exactly T_INT cycles, then SAMPLE, `px_sh`=1 for exactly T_SH cycles, then CONVERT.
- CONVERT: `adc_start`=1 only in its first cycle. `adc_done` is sampled in every CONVERT cycle, the first included; on `adc_done`, latch `adc_data` and clear `out_err`, then go to OUTPUT. If no `adc_done` arrives within ADC_TIMEOUT CONVERT cycles, set `out_data` to all ones and `out_err`=1, then go to OUTPUT.
- OUTPUT: `out_valid`=1. `out_row`, `out_col`, `out_data` and `out_err` hold stable until `out_valid & out_ready`, then go to IDLE.
- `adc_done` outside CONVERT: ignored.
- `addr_valid` outside IDLE: ignored; no address is queued.
- At most one phase output (`px_rst`, `px_int`, `px_sh`) is high in any cycle.
- All control outputs are registered.

## Timing
- Reset: all outputs 0 while `rst`=0, including `addr_ready`. State goes to IDLE asynchronously. `addr_ready` rises on the first clock edge after release.
- Reset mid-operation: all phase outputs and `adc_start` drop immediately. The latched address and any pending sample are discarded; no `out_valid` is produced for them.
- Accept at edge k: RESET occupies cycles k+1..k+T_RST. CONVERT begins at k+T_RST+T_INT+T_SH+1.
- Minimum latency, with `adc_done` in the first CONVERT cycle: `out_valid` is first high at k+T_RST+T_INT+T_SH+2, which is 108 cycles with defaults.
- Timeout: `out_valid` is first high one cycle after the ADC_TIMEOUT-th CONVERT cycle.
- Back-to-back: the next accept can occur no earlier than one cycle after the output handshake. Minimum pixel period is T_RST+T_INT+T_SH+3 cycles.
- Phase counter width: $clog2 of max(T_INT, ADC_TIMEOUT)+1. Counters do not wrap.

## Structure
- Package `roic_pkg`: state enum `seq_state_t`; default timing constants; `ROW_W`, `COL_W`, `DATA_W` defaults shared with the traversal FSM.
- Sub-module `phase_timer`: loadable down-counter with a one-cycle `expire` output. It is instantiated once and reloaded at every state transition.

## Test plan
- Single pixel: row 5, col 17, `adc_done` in the 3rd CONVERT cycle with data 0x1A3C. Required: `px_rst` high 4 cycles, `px_int` 100, `px_sh` 2; `adc_start` high 1 cycle; `out_data`=0x1A3C, `out_row`=5, `out_col`=17, `out_err`=0.
- Backpressure: `out_ready` held low 10 cycles. Required: `out_valid`, `out_data` and the address tag stay stable; `addr_ready` stays 0 until the handshake; IDLE is re-entered the cycle after the handshake.
- ADC timeout: `adc_done` never asserted. Required: `out_valid` after exactly 64 CONVERT cycles, `out_data`=0x3FFF, `out_err`=1.
- Back-to-back: `addr_valid` held high with `out_ready`=1 and `adc_done` in the first CONVERT cycle. Required: accepts spaced exactly 109 cycles apart; addresses emerge in order.
- Reset mid-INTEGRATE: assert `rst`=0 at cycle 50 of integration. Required: `px_int` drops without waiting for a clock edge; no `out_valid`; `addr_ready`=1 one edge after release.
- Stray `adc_done` pulse during INTEGRATE. Required: ignored; phase lengths unchanged; the sample comes from the later in-window `adc_done`.

Source files
------------

// File: rtl/roic_pixel_sequencer_pkg.sv
// Shared types and default timing for the ROIC pixel readout chain.
// The address/data widths are also used by the row/column traversal FSM.
package roic_pkg;

    localparam int DEF_ROW_W       = 9;
    localparam int DEF_COL_W       = 10;
    localparam int DEF_DATA_W      = 14;
    localparam int DEF_T_RST       = 4;
    localparam int DEF_T_INT       = 100;
    localparam int DEF_T_SH        = 2;
    localparam int DEF_ADC_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_INTEGRATE = 3'd2,
        ST_SAMPLE    = 3'd3,
        ST_CONVERT   = 3'd4,
        ST_OUTPUT    = 3'd5
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/roic_pixel_sequencer_phase_timer.sv
// Loadable down-counter shared by all analog phases and the ADC wait window.
// o_expire is high during the last cycle of a loaded interval, so loading N
// gives exactly N cycles before expiry. The counter parks at zero.
module phase_timer
    import roic_pkg::*;
#(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_cnt;

    // Reload on request, otherwise count down and stop at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/roic_pixel_sequencer.sv
// Per-pixel analog phase sequencer: pixel reset, integrate, sample-and-hold,
// one ADC conversion, then an address-tagged sample to the frame buffer.
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | addr_ready high, waiting for a pixel address
// ST_RESET     | px_rst high for T_RST cycles
// ST_INTEGRATE | px_int high for T_INT cycles
// ST_SAMPLE    | px_sh high for T_SH cycles
// ST_CONVERT   | adc_start in first cycle, wait up to ADC_TIMEOUT for adc_done
// ST_OUTPUT    | out_valid high until out_ready
module roic_pixel_sequencer
    import roic_pkg::*;
#(
    parameter int ROW_W       = DEF_ROW_W,
    parameter int COL_W       = DEF_COL_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int T_RST       = DEF_T_RST,
    parameter int T_INT       = DEF_T_INT,
    parameter int T_SH        = DEF_T_SH,
    parameter int ADC_TIMEOUT = DEF_ADC_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              addr_valid,
    output logic              addr_ready,
    input  logic [ROW_W-1:0]  row_addr,
    input  logic [COL_W-1:0]  col_addr,
    output logic              px_rst,
    output logic              px_int,
    output logic              px_sh,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROW_W-1:0]  out_row,
    output logic [COL_W-1:0]  out_col,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(max_int(T_INT, ADC_TIMEOUT) + 1);

    seq_state_t        r_state;
    logic              r_addr_ready;
    logic              r_px_rst;
    logic              r_px_int;
    logic              r_px_sh;
    logic              r_adc_start;
    logic              r_out_valid;
    logic              r_out_err;
    logic              r_busy;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [DATA_W-1:0] r_data;

    logic              w_accept;
    logic              w_handshake;
    logic              w_expire;
    logic              w_tmr_load;
    logic [CNT_W-1:0]  w_tmr_val;

    // r_addr_ready is only ever high in IDLE, so it doubles as the state qualifier.
    assign w_accept    = addr_valid & r_addr_ready;
    assign w_handshake = r_out_valid & out_ready;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expire   (w_expire)
    );

    // Reload the phase timer with the length of the state being entered.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CNT_W'(T_RST);
                end
            end
            ST_RESET: begin
                if (w_expire) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CNT_W'(T_INT);
                end
            end
            ST_INTEGRATE: begin
                if (w_expire) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CNT_W'(T_SH);
                end
            end
            ST_SAMPLE: begin
                if (w_expire) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = CNT_W'(ADC_TIMEOUT);
                end
            end
            ST_CONVERT: begin
                if (adc_done || w_expire) begin
                    w_tmr_load = 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (w_handshake) begin
                    w_tmr_load = 1'b1;
                end
            end
            default: begin
                w_tmr_load = 1'b1;
            end
        endcase
    end

    // Sequencer FSM with all control outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_addr_ready <= 1'b0;
            r_px_rst     <= 1'b0;
            r_px_int     <= 1'b0;
            r_px_sh      <= 1'b0;
            r_adc_start  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_err    <= 1'b0;
            r_busy       <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_data       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_row        <= row_addr;
                        r_col        <= col_addr;
                        r_addr_ready <= 1'b0;
                        r_busy       <= 1'b1;
                        r_px_rst     <= 1'b1;
                        r_state      <= ST_RESET;
                    end else begin
                        r_addr_ready <= 1'b1;
                    end
                end
                ST_RESET: begin
                    if (w_expire) begin
                        r_px_rst <= 1'b0;
                        r_px_int <= 1'b1;
                        r_state  <= ST_INTEGRATE;
                    end
                end
                ST_INTEGRATE: begin
                    if (w_expire) begin
                        r_px_int <= 1'b0;
                        r_px_sh  <= 1'b1;
                        r_state  <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (w_expire) begin
                        r_px_sh     <= 1'b0;
                        r_adc_start <= 1'b1;
                        r_state     <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    r_adc_start <= 1'b0;
                    // A done in the final window cycle still counts as a good sample.
                    if (adc_done) begin
                        r_data      <= adc_data;
                        r_out_err   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUTPUT;
                    end else if (w_expire) begin
                        r_data      <= '1;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (w_handshake) begin
                        r_out_valid  <= 1'b0;
                        r_busy       <= 1'b0;
                        r_addr_ready <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign addr_ready = r_addr_ready;
    assign px_rst     = r_px_rst;
    assign px_int     = r_px_int;
    assign px_sh      = r_px_sh;
    assign adc_start  = r_adc_start;
    assign out_valid  = r_out_valid;
    assign out_row    = r_row;
    assign out_col    = r_col;
    assign out_data   = r_data;
    assign out_err    = r_out_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_roic_pixel_sequencer.sv
// Bench for roic_pixel_sequencer. Expected phase windows, latencies and
// samples are derived arithmetically from the accept cycle and the timing
// parameters; inputs change and outputs are sampled on the falling edge.
module tb_roic_pixel_sequencer;

    localparam int ROW_W       = 9;
    localparam int COL_W       = 10;
    localparam int DATA_W      = 14;
    localparam int T_RST       = 4;
    localparam int T_INT       = 100;
    localparam int T_SH        = 2;
    localparam int ADC_TIMEOUT = 64;
    localparam int S           = T_RST + T_INT + T_SH;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              addr_valid = 1'b0;
    logic              addr_ready;
    logic [ROW_W-1:0]  row_addr = '0;
    logic [COL_W-1:0]  col_addr = '0;
    logic              px_rst;
    logic              px_int;
    logic              px_sh;
    logic              adc_start;
    logic              adc_done = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ROW_W-1:0]  out_row;
    logic [COL_W-1:0]  out_col;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic              busy;

    int cyc         = 0;
    int n_cmp       = 0;
    int n_err       = 0;
    int last_accept = -1000;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    roic_pixel_sequencer #(
        .ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W),
        .T_RST(T_RST), .T_INT(T_INT), .T_SH(T_SH), .ADC_TIMEOUT(ADC_TIMEOUT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .row_addr   (row_addr),
        .col_addr   (col_addr),
        .px_rst     (px_rst),
        .px_int     (px_int),
        .px_sh      (px_sh),
        .adc_start  (adc_start),
        .adc_done   (adc_done),
        .adc_data   (adc_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_data   (out_data),
        .out_err    (out_err),
        .busy       (busy)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // d: CONVERT cycle (1-based) carrying adc_done; outside 1..ADC_TIMEOUT means never.
    // stray: cycle offset from accept for an out-of-window adc_done pulse, -1 for none.
    task automatic do_pixel(input int row, input int col, input int d, input int data,
                            input int stray, input int bp, input bit hold, input bit b2b_chk);
        int rel, v_rel, wait_n;
        int n_rst, n_int, n_sh, n_start, n_wave_bad, n_overlap, n_ar_bad, n_unstable;
        bit er, ei, es, ea, exp_err;
        int exp_v;
        logic [DATA_W-1:0] exp_data;
        logic [ROW_W+COL_W+DATA_W:0] snap;

        exp_err  = (d < 1) || (d > ADC_TIMEOUT);
        exp_data = exp_err ? {DATA_W{1'b1}} : DATA_W'(data);
        exp_v    = exp_err ? (S + ADC_TIMEOUT) : (S + d);

        out_ready = (bp == 0);
        wait_n = 0;
        while (!addr_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check_val("addr_ready_before_accept", addr_ready, 1);

        addr_valid = 1'b1;
        row_addr   = ROW_W'(row);
        col_addr   = COL_W'(col);
        @(negedge clk);
        if (b2b_chk) check_val("b2b_accept_spacing", cyc - last_accept, S + 3);
        last_accept = cyc;
        if (!hold) addr_valid = 1'b0;
        row_addr = ROW_W'($urandom);
        col_addr = COL_W'($urandom);

        rel = 0; v_rel = -1;
        n_rst = 0; n_int = 0; n_sh = 0; n_start = 0;
        n_wave_bad = 0; n_overlap = 0; n_ar_bad = 0;
        while (rel <= S + ADC_TIMEOUT + 4) begin
            if (out_valid) begin
                v_rel = rel;
                break;
            end
            er = (rel < T_RST);
            ei = (rel >= T_RST) && (rel < T_RST + T_INT);
            es = (rel >= T_RST + T_INT) && (rel < S);
            ea = (rel == S);
            if ({px_rst, px_int, px_sh, adc_start} !== {er, ei, es, ea}) n_wave_bad++;
            if (int'(px_rst) + int'(px_int) + int'(px_sh) > 1) n_overlap++;
            if (addr_ready || !busy) n_ar_bad++;
            n_rst   += int'(px_rst);
            n_int   += int'(px_int);
            n_sh    += int'(px_sh);
            n_start += int'(adc_start);
            adc_done = (!exp_err && rel == S + d - 1) || (rel == stray);
            adc_data = (!exp_err && rel == S + d - 1) ? DATA_W'(data) : DATA_W'($urandom);
            @(negedge clk);
            rel++;
        end
        adc_done = 1'b0;

        check_val("px_rst_cycles", n_rst, T_RST);
        check_val("px_int_cycles", n_int, T_INT);
        check_val("px_sh_cycles", n_sh, T_SH);
        check_val("adc_start_cycles", n_start, 1);
        check_val("phase_window_errors", n_wave_bad, 0);
        check_val("phase_overlap", n_overlap, 0);
        check_val("busy_not_ready_errors", n_ar_bad, 0);
        check_val("out_valid_latency", v_rel, exp_v);
        check_val("out_row", out_row, row);
        check_val("out_col", out_col, col);
        check_val("out_data", out_data, exp_data);
        check_val("out_err", out_err, exp_err);

        snap = {out_row, out_col, out_data, out_err};
        n_unstable = 0;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (!out_valid || ({out_row, out_col, out_data, out_err} !== snap) || addr_ready)
                n_unstable++;
        end
        if (bp > 0) check_val("backpressure_stable", n_unstable, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check_val("post_hs_idle", {out_valid, addr_ready, busy}, 3'b010);
    endtask

    task automatic do_reset_mid();
        int n_valid;
        while (!addr_ready) @(negedge clk);
        addr_valid = 1'b1;
        row_addr   = ROW_W'(9);
        col_addr   = COL_W'(33);
        @(negedge clk);
        addr_valid = 1'b0;
        repeat (T_RST + 49) @(negedge clk);
        check_val("rmid_px_int_before", px_int, 1);
        #1 rst = 1'b0;
        #1;
        check_val("rmid_px_int_async", px_int, 0);
        check_val("rmid_outputs_zero", {addr_ready, busy, px_rst, px_sh, adc_start, out_valid}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("rmid_addr_ready_release", addr_ready, 1);
        n_valid = 0;
        repeat (S + ADC_TIMEOUT + 10) begin
            @(negedge clk);
            if (out_valid) n_valid++;
        end
        check_val("rmid_no_out_valid", n_valid, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, stray;
        rst       = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_ctrl_outputs",
                  {addr_ready, px_rst, px_int, px_sh, adc_start, out_valid, out_err, busy}, 0);
        check_val("reset_tag_data", {out_row, out_col, out_data}, 0);
        rst = 1'b1;
        @(negedge clk);
        check_val("addr_ready_after_release", addr_ready, 1);

        // single pixel, done in 3rd CONVERT cycle
        do_pixel(5, 17, 3, 'h1A3C, -1, 0, 1'b0, 1'b0);
        // backpressure
        do_pixel(300, 600, 1, int'($urandom_range(0, 16383)), -1, 10, 1'b0, 1'b0);
        // ADC timeout
        do_pixel(511, 639, 0, 0, -1, 0, 1'b0, 1'b0);
        // done in the last window cycle
        do_pixel(1, 2, ADC_TIMEOUT, 'h0055, -1, 0, 1'b0, 1'b0);
        // stray adc_done during integration
        do_pixel(7, 8, 5, 'h0123, T_RST + 30, 0, 1'b0, 1'b0);
        // back-to-back with addr_valid held high
        for (int i = 0; i < 4; i++)
            do_pixel(i * 3 + 1, i * 5 + 2, 1, int'($urandom_range(0, 16383)), -1, 0, 1'b1, i > 0);
        addr_valid = 1'b0;

        do_reset_mid();

        for (int i = 0; i < 12; i++) begin
            d     = int'($urandom_range(0, ADC_TIMEOUT + 6));
            stray = ($urandom_range(0, 1) == 1) ? T_RST + int'($urandom_range(0, T_INT - 1)) : -1;
            do_pixel(int'($urandom_range(0, 511)), int'($urandom_range(0, 639)), d,
                     int'($urandom_range(0, 16383)), stray, int'($urandom_range(0, 4)), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
